led_flash_arbiter: RTL and testbench
====================================

LED_FLASH_ARBITER -- requirements
Module: led_flash_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 8: cycles the grant is held after the KEY pulse; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 32: maximum cycles spent waiting for the flasher to return to idle; legal range 1..255.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  system clock; all state updates on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 REQ  input  4  level request per requester; bit i = requester i.
REQ-007 REQ_SEL  input  4  SEL value requested by requester i; sampled only at grant.
REQ-008 FLASH_STATE  input  2  STATE output of the shared led_flash; 2'd0 = idle.
REQ-009 GNT  output  4  one-hot grant; all-zero when no owner.
REQ-010 KEY_OUT  output  1  KEY drive to led_flash.
REQ-011 SEL_OUT  output  1  SEL drive to led_flash.
REQ-012 BUSY  output  1  high whenever FSM is not IDLE.
REQ-013 TIMEOUT_ERR  output  1  sticky flag: a wait-for-idle timed out.
REQ-014 FSM_STATE  output  3  debug copy of FSM encoding.

Function
REQ-015 FSM states and encodings: IDLE=0, SETUP=1, PULSE=2, HOLD=3, WAIT_IDLE=4; encodings 5..7 unreachable, and recovery from them goes to IDLE.
REQ-016 IDLE: if REQ != 0, the arbiter picks the winner round-robin, searching from rr_ptr upward mod 4, latches the winner index and REQ_SEL[winner], and goes to SETUP; otherwise it stays in IDLE.
REQ-017 rr_ptr: reset value 0; set to (winner+1) mod 4 at grant, so index 3 wraps to 0.
REQ-018 SETUP lasts 1 cycle; GNT = one-hot(winner); SEL_OUT = latched SEL; KEY_OUT = 0.
REQ-019 PULSE lasts 1 cycle; KEY_OUT = 1, asserted only in this state; GNT and SEL_OUT are held.
REQ-020 HOLD lasts exactly HOLD_CYCLES cycles, counted by hold_cnt; GNT and SEL_OUT are held; KEY_OUT = 0.
REQ-021 WAIT_IDLE: if FLASH_STATE == 2'd0, go to IDLE next cycle; otherwise increment wait_cnt; after TIMEOUT_CYCLES non-idle cycles, set TIMEOUT_ERR and go to IDLE.
REQ-022 In IDLE: GNT = 0, KEY_OUT = 0, SEL_OUT = 0; at least one IDLE cycle separates consecutive grants.
REQ-023 Latency: REQ sampled high at edge t gives GNT at t+1 and KEY_OUT high during cycle t+2.
REQ-024 After grant, changes to REQ or REQ_SEL are ignored; a requester dropping REQ mid-sequence does not abort the sequence.
REQ-025 Requests arriving while BUSY wait until IDLE; no request is lost while REQ is held.
REQ-026 TIMEOUT_ERR is sticky; only reset clears it.
REQ-027 hold_cnt and wait_cnt are 8 bits wide, cleared on entry to their state, and never wrap.

Reset
REQ-028 RST_N low immediately forces FSM = IDLE, rr_ptr = 0, counters = 0, GNT = 0, KEY_OUT = 0, SEL_OUT = 0, BUSY = 0, TIMEOUT_ERR = 0, independent of CLK, including mid-sequence.
REQ-029 On the first edge after RST_N rises, the FSM is in IDLE and may grant on that edge.

Structure
REQ-030 Package led_flash_pkg holds the FSM state encodings, the FLASH_IDLE = 2'd0 constant and the HOLD/TIMEOUT defaults.
REQ-031 One combinational sub-module, led_rr_pick (inputs REQ and rr_ptr; outputs valid and a 2-bit index), holds the round-robin search.

Verification
REQ-032 REQ=4'b0100, REQ_SEL=4'b0100, FLASH_STATE=0 -> GNT=4'b0100 for 11 cycles, SEL_OUT=1 throughout, KEY_OUT high exactly 1 cycle, 2nd cycle of grant.
REQ-033 REQ=4'b1111 held -> grants in order 0,1,2,3,0, each separated by 1 IDLE cycle with GNT=0.
REQ-034 Grant active with FLASH_STATE stuck at 2'd1 -> 32 WAIT_IDLE cycles, then TIMEOUT_ERR=1 and FSM=IDLE; TIMEOUT_ERR stays 1 through later grants until RST_N is pulsed.
REQ-035 RST_N low during HOLD -> all outputs 0 immediately; then REQ=4'b1010 after release -> GNT=4'b0010.
REQ-036 Requester 1 granted with REQ_SEL[1]=1, then REQ[1] and REQ_SEL[1] dropped during HOLD -> sequence completes, SEL_OUT stays 1 until IDLE.
REQ-037 Last grant index 3, then REQ=4'b1001 -> GNT=4'b0001 (pointer wrap).

Source files
------------

// File: rtl/led_flash_pkg.sv
// Shared constants for the led_flash arbiter: FSM encodings,
// flasher idle code and default timing parameters.
package led_flash_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    localparam logic [1:0] FLASH_IDLE = 2'd0;

    localparam int unsigned HOLD_DEFAULT    = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 32;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Round-robin search over four requesters, starting at ptr and
// moving upward mod 4.
module led_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] k;

    // Walk offsets high to low so the closest requester wins last.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        k     = ptr;
        for (int i = 3; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                valid = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/led_flash_arbiter.sv
// Shares one led_flash between four requesters: grant, pulse KEY,
// hold, then wait for the flasher to return to idle.
module led_flash_arbiter
    import led_flash_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = HOLD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] req_sel,
    input  logic [1:0] flash_state,
    output logic [3:0] gnt,
    output logic       key_out,
    output logic       sel_out,
    output logic       busy,
    output logic       timeout_err,
    output logic [2:0] fsm_state
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0] state;
    logic [1:0] owner;
    logic       sel_q;
    logic [1:0] rr_ptr;
    logic [7:0] hold_cnt;
    logic [7:0] wait_cnt;
    logic       err_q;

    logic       pick_valid;
    logic [1:0] pick_idx;

    led_rr_pick u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= 2'd0;
            sel_q    <= 1'b0;
            rr_ptr   <= 2'd0;
            hold_cnt <= 8'd0;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner  <= pick_idx;
                        sel_q  <= req_sel[pick_idx];
                        rr_ptr <= pick_idx + 2'd1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: state <= ST_PULSE;
                ST_PULSE: begin
                    hold_cnt <= 8'd0;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        wait_cnt <= 8'd0;
                        state    <= ST_WAIT;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (flash_state == FLASH_IDLE) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic active;

    always_comb begin
        active = 1'b0;
        unique case (1'b1)
            (state == ST_SETUP): active = 1'b1;
            (state == ST_PULSE): active = 1'b1;
            (state == ST_HOLD):  active = 1'b1;
            (state == ST_WAIT):  active = 1'b1;
            default:             active = 1'b0;
        endcase
    end

    assign gnt         = active ? onehot4(owner) : 4'b0000;
    assign sel_out     = active & sel_q;
    assign key_out     = (state == ST_PULSE);
    assign busy        = (state != ST_IDLE);
    assign timeout_err = err_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_led_flash_arbiter.sv
// Randomised self-checking bench for led_flash_arbiter against a
// transaction-level model of grant order and sequence length.
module tb_led_flash_arbiter;

    localparam int H = 8;
    localparam int T = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] req_sel = 4'b0;
    logic [1:0] flash_state = 2'd0;
    logic [3:0] gnt;
    logic       key_out;
    logic       sel_out;
    logic       busy;
    logic       timeout_err;
    logic [2:0] fsm_state;

    int vectors = 0;
    int errors  = 0;
    int m_ptr   = 0;
    bit m_err   = 1'b0;

    led_flash_arbiter #(
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_sel     (req_sel),
        .flash_state (flash_state),
        .gnt         (gnt),
        .key_out     (key_out),
        .sel_out     (sel_out),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (r[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic idle_check(input string name);
        vectors++;
        if ({gnt, key_out, sel_out, busy, fsm_state, timeout_err} !==
            {4'b0, 1'b0, 1'b0, 1'b0, 3'd0, m_err}) begin
            errors++;
            $display("FAIL %s: got gnt=%b key=%b sel=%b busy=%b st=%0d err=%b, want 0/0/0/0/0 err=%b",
                     name, gnt, key_out, sel_out, busy, fsm_state, timeout_err, m_err);
        end
    endtask

    // Called at a negedge with the DUT idle; ends at the negedge of
    // the idle cycle that follows the sequence.
    task automatic transact(input string name, input logic [3:0] r,
                            input logic [3:0] s, input int busy_len,
                            input bit junk);
        int w, total, wait_len;
        logic [3:0] eg;
        logic es, ek;
        logic [2:0] est;
        req = r;
        req_sel = s;
        flash_state = 2'd1;
        w = pick(r, m_ptr);
        eg = 4'b0001 << w;
        es = s[w];
        m_ptr = (w + 1) % 4;
        wait_len = (busy_len >= T) ? T : busy_len + 1;
        total = 2 + H + wait_len;
        @(posedge clk); #1;
        for (int k = 0; k < total; k++) begin
            flash_state = (k < 2 + H + busy_len) ?
                          2'($urandom_range(1, 3)) : 2'd0;
            if (junk) begin
                req = 4'($urandom);
                req_sel = 4'($urandom);
            end
            @(negedge clk);
            ek = (k == 1);
            est = (k == 0) ? 3'd1 : (k == 1) ? 3'd2 :
                  (k < 2 + H) ? 3'd3 : 3'd4;
            vectors++;
            if ({gnt, key_out, sel_out, busy, fsm_state, timeout_err} !==
                {eg, ek, es, 1'b1, est, m_err}) begin
                errors++;
                $display("FAIL %s cyc%0d: got gnt=%b key=%b sel=%b busy=%b st=%0d err=%b, want gnt=%b key=%b sel=%b busy=1 st=%0d err=%b",
                         name, k, gnt, key_out, sel_out, busy, fsm_state, timeout_err,
                         eg, ek, es, est, m_err);
            end
            @(posedge clk); #1;
        end
        if (busy_len >= T) m_err = 1'b1;
        req = 4'b0;
        req_sel = 4'b0;
        flash_state = 2'd0;
        @(negedge clk);
        idle_check({name, "_gap"});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        #3;
        idle_check("reset_async");
        repeat (2) @(negedge clk);
        idle_check("reset_held");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            idle_check("idle_no_req");
        end
    endtask

    task automatic test_single();
        transact("single", 4'b0100, 4'b0100, 0, 1'b0);
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++)
            transact("rr", 4'b1111, 4'($urandom), $urandom_range(0, 3), 1'b0);
    endtask

    task automatic test_wrap();
        transact("wrap_a", 4'b1000, 4'b1000, 1, 1'b0);
        transact("wrap_b", 4'b1001, 4'b0001, 0, 1'b0);
    endtask

    task automatic test_drop();
        transact("drop", 4'b0010, 4'b0010, 2, 1'b1);
    endtask

    task automatic test_timeout();
        transact("timeout", 4'b0001, 4'b0000, 40, 1'b0);
        transact("after_to", 4'b0100, 4'b0000, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        req = 4'b0001;
        req_sel = 4'b0001;
        flash_state = 2'd1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        m_ptr = 0;
        m_err = 1'b0;
        #1;
        idle_check("reset_mid");
        req = 4'b0;
        req_sel = 4'b0;
        flash_state = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        transact("post_reset", 4'b1010, 4'b0010, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            transact("rand", r, 4'($urandom),
                     ($urandom_range(0, 9) == 0) ? 35 : $urandom_range(0, 6),
                     1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
